// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between the I-cache (m0) and D-cache (m1) controllers; round-robin, one transaction in flight.
// Latency: accept -> mem_req_valid next cycle, >=3 cycles per transaction; backpressure via req/resp ready on both sides.
module cache_mem_arbiter #(
  parameter int BLOCK_SIZE = 128,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_write,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [BLOCK_SIZE-1:0] m0_wdata,
  output logic                  m0_resp_valid,
  input  logic                  m0_resp_ready,
  output logic [BLOCK_SIZE-1:0] m0_rdata,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_write,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [BLOCK_SIZE-1:0] m1_wdata,
  output logic                  m1_resp_valid,
  input  logic                  m1_resp_ready,
  output logic [BLOCK_SIZE-1:0] m1_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [BLOCK_SIZE-1:0] mem_wdata,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [BLOCK_SIZE-1:0] mem_rdata,
  output logic                  grant_id,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   winner;
  logic   any_valid;
  logic   accept;
  logic   resp_done;
  logic   in_resp;

  // Only one requester valid wins outright; a tie goes to whoever was not served last.
  always_comb begin
    any_valid = m0_req_valid | m1_req_valid;
    if (m0_req_valid && m1_req_valid) winner = ~last_grant;
    else                              winner = ~m0_req_valid;
  end

  assign in_resp   = (state == RESP);
  assign accept    = (state == IDLE) && any_valid;
  assign resp_done = in_resp && mem_resp_valid && mem_resp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = REQ;
      REQ:     if (mem_req_ready) state_nxt = RESP;
      RESP:    if (resp_done)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Ready is qualified by rst so nothing handshakes while reset is held.
  always_comb begin
    m0_req_ready   = rst && (state == IDLE) && any_valid && !winner;
    m1_req_ready   = rst && (state == IDLE) && any_valid &&  winner;
    mem_req_valid  = (state == REQ);
    mem_resp_ready = in_resp && (grant_id ? m1_resp_ready : m0_resp_ready);
    m0_resp_valid  = in_resp && !grant_id && mem_resp_valid;
    m1_resp_valid  = in_resp &&  grant_id && mem_resp_valid;
    m0_rdata       = (in_resp && !grant_id) ? mem_rdata : '0;
    m1_rdata       = (in_resp &&  grant_id) ? mem_rdata : '0;
    busy           = (state != IDLE);
  end

  // Command is captured at accept and held so the memory side sees stable fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        grant_id  <= winner;
        mem_write <= winner ? m1_write : m0_write;
        mem_addr  <= winner ? m1_addr  : m0_addr;
        mem_wdata <= winner ? m1_wdata : m0_wdata;
      end
      if (resp_done) last_grant <= grant_id;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: inputs driven and outputs sampled around the falling edge.
module tb_cache_mem_arbiter;

  localparam int BS = 128;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_req_valid = 0, m0_write = 0, m0_resp_ready = 0;
  logic [AW-1:0] m0_addr = '0;
  logic [BS-1:0] m0_wdata = '0;
  logic          m1_req_valid = 0, m1_write = 0, m1_resp_ready = 0;
  logic [AW-1:0] m1_addr = '0;
  logic [BS-1:0] m1_wdata = '0;
  logic          mem_req_ready = 0, mem_resp_valid = 0;
  logic [BS-1:0] mem_rdata = '0;
  logic          m0_req_ready, m0_resp_valid, m1_req_ready, m1_resp_valid;
  logic [BS-1:0] m0_rdata, m1_rdata, mem_wdata;
  logic          mem_req_valid, mem_write, mem_resp_ready, grant_id, busy;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int failures = 0;

  localparam logic [BS-1:0] RD_A5 = {16{8'hA5}};
  localparam logic [BS-1:0] WD    = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.BLOCK_SIZE(BS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_write(m0_write),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_resp_valid(m0_resp_valid),
    .m0_resp_ready(m0_resp_ready), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_write(m1_write),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_resp_valid(m1_resp_valid),
    .m1_resp_ready(m1_resp_ready), .m1_rdata(m1_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  task automatic clear_inputs();
    m0_req_valid = 0; m0_write = 0; m0_resp_ready = 0;
    m1_req_valid = 0; m1_write = 0; m1_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    m0_req_valid = 1; m1_req_valid = 1; mem_resp_valid = 1; m0_resp_ready = 1;
    #1;
    checks++; if ({m0_req_ready, m1_req_ready} !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", {m0_req_ready, m1_req_ready}); end
    checks++; if ({busy, mem_req_valid, mem_resp_ready, grant_id} !== 4'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, mem_req_valid, mem_resp_ready, grant_id}); end
    checks++; if ({mem_write, mem_addr, mem_wdata} !== '0) begin failures++; $display("FAIL reset_mem_regs got=%h exp=0", {mem_write, mem_addr, mem_wdata}); end
    checks++; if ({m0_resp_valid, m1_resp_valid} !== 2'b00) begin failures++; $display("FAIL reset_resp_valid got=%b exp=00", {m0_resp_valid, m1_resp_valid}); end
    @(negedge clk);
    clear_inputs();
    rst = 1;
  endtask

  task automatic test_read();
    m0_req_valid = 1; m0_write = 0; m0_addr = 32'h40;
    #1;
    checks++; if ({m1_req_ready, m0_req_ready} !== 2'b01) begin failures++; $display("FAIL read_accept got=%b exp=01", {m1_req_ready, m0_req_ready}); end
    @(negedge clk);
    m0_req_valid = 0; m0_addr = 32'hFFFF_FFFF; mem_req_ready = 1;
    #1;
    checks++; if ({mem_req_valid, mem_write, grant_id} !== 3'b100) begin failures++; $display("FAIL read_mem_req got=%b exp=100", {mem_req_valid, mem_write, grant_id}); end
    checks++; if (mem_addr !== 32'h40) begin failures++; $display("FAIL read_mem_addr got=%h exp=40", mem_addr); end
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = RD_A5; m0_resp_ready = 1;
    #1;
    checks++; if ({m0_resp_valid, m1_resp_valid, mem_resp_ready} !== 3'b101) begin failures++; $display("FAIL read_resp_ctl got=%b exp=101", {m0_resp_valid, m1_resp_valid, mem_resp_ready}); end
    checks++; if (m0_rdata !== RD_A5) begin failures++; $display("FAIL read_rdata got=%h exp=%h", m0_rdata, RD_A5); end
    checks++; if (m1_rdata !== '0) begin failures++; $display("FAIL read_m1_rdata got=%h exp=0", m1_rdata); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if ({busy, mem_req_valid} !== 2'b00) begin failures++; $display("FAIL read_done got=%b exp=00", {busy, mem_req_valid}); end
    checks++; if (mem_addr !== 32'h40) begin failures++; $display("FAIL read_addr_hold got=%h exp=40", mem_addr); end
    @(negedge clk);
  endtask

  task automatic test_writeback();
    m1_req_valid = 1; m1_write = 1; m1_addr = 32'h80; m1_wdata = WD;
    #1;
    checks++; if ({m1_req_ready, m0_req_ready} !== 2'b10) begin failures++; $display("FAIL wb_accept got=%b exp=10", {m1_req_ready, m0_req_ready}); end
    @(negedge clk);
    m1_req_valid = 0; m1_write = 0; m1_addr = 32'hDEAD_BEEF; m1_wdata = '0; mem_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({mem_req_valid, mem_write, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h80, WD})
        begin failures++; $display("FAIL wb_hold cyc=%0d got=%b/%b/%h/%h exp=1/1/80/%h", i, mem_req_valid, mem_write, mem_addr, mem_wdata, WD); end
      @(negedge clk);
    end
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; m1_resp_ready = 1;
    #1;
    checks++; if ({m1_resp_valid, m0_resp_valid, mem_resp_ready, grant_id} !== 4'b1011) begin failures++; $display("FAIL wb_ack got=%b exp=1011", {m1_resp_valid, m0_resp_valid, mem_resp_ready, grant_id}); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wb_done busy got=%b exp=0", busy); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic e;
    m0_addr = 32'h100; m1_addr = 32'h200; m0_write = 0; m1_write = 0;
    m0_req_valid = 1; m1_req_valid = 1; mem_req_ready = 1; mem_resp_valid = 1;
    m0_resp_ready = 1; m1_resp_ready = 1;
    for (int t = 0; t < 4; t++) begin
      e = (t % 2 == 1);
      #1;
      checks++; if ({m1_req_ready, m0_req_ready} !== (e ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_ready txn=%0d got=%b exp=%b", t, {m1_req_ready, m0_req_ready}, e ? 2'b10 : 2'b01); end
      @(negedge clk);
      #1;
      checks++; if ({m1_req_ready, m0_req_ready, grant_id} !== {2'b00, e}) begin failures++; $display("FAIL rr_grant txn=%0d got=%b exp=%b", t, {m1_req_ready, m0_req_ready, grant_id}, {2'b00, e}); end
      checks++; if (mem_addr !== (e ? 32'h200 : 32'h100)) begin failures++; $display("FAIL rr_addr txn=%0d got=%h exp=%h", t, mem_addr, e ? 32'h200 : 32'h100); end
      @(negedge clk);
      #1;
      checks++; if ({m1_resp_valid, m0_resp_valid} !== (e ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_resp txn=%0d got=%b exp=%b", t, {m1_resp_valid, m0_resp_valid}, e ? 2'b10 : 2'b01); end
      @(negedge clk);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_resp_stall();
    m0_req_valid = 1; m0_write = 0; m0_addr = 32'hC0;
    #1;
    checks++; if (m0_req_ready !== 1'b1) begin failures++; $display("FAIL stall_accept got=%b exp=1", m0_req_ready); end
    @(negedge clk);
    m0_req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 128'h5A; m0_resp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({mem_resp_ready, m0_resp_valid, busy} !== 3'b011) begin failures++; $display("FAIL stall_hold cyc=%0d got=%b exp=011", i, {mem_resp_ready, m0_resp_valid, busy}); end
      checks++; if (m0_rdata !== 128'h5A) begin failures++; $display("FAIL stall_rdata cyc=%0d got=%h exp=5a", i, m0_rdata); end
      @(negedge clk);
    end
    m0_resp_ready = 1;
    #1;
    checks++; if (mem_resp_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", mem_resp_ready); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_done busy got=%b exp=0", busy); end
    @(negedge clk);
  endtask

  task automatic test_idle_stray();
    mem_resp_valid = 1; mem_rdata = RD_A5; m0_resp_ready = 1; m1_resp_ready = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if ({m0_resp_valid, m1_resp_valid, mem_resp_ready, busy} !== 4'b0) begin failures++; $display("FAIL stray_idle cyc=%0d got=%b exp=0000", i, {m0_resp_valid, m1_resp_valid, mem_resp_ready, busy}); end
      @(negedge clk);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    m0_req_valid = 1; m0_write = 1; m0_addr = 32'hC4; m0_wdata = WD;
    @(negedge clk);
    m0_req_valid = 0; mem_req_ready = 0;
    #1;
    checks++; if ({busy, mem_req_valid, mem_write} !== 3'b111) begin failures++; $display("FAIL mid_in_req got=%b exp=111", {busy, mem_req_valid, mem_write}); end
    rst = 0; m0_req_valid = 1; m1_req_valid = 1; mem_resp_valid = 1; m0_resp_ready = 1; mem_rdata = RD_A5;
    #1;
    checks++; if ({m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, m0_rdata, m1_rdata, mem_req_valid,
                   mem_write, mem_addr, mem_wdata, mem_resp_ready, grant_id, busy} !== '0)
      begin failures++; $display("FAIL mid_reset_outputs got=%b%b%b%b %b%b%b addr=%h busy=%b exp=all0", m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, mem_req_valid, mem_write, mem_resp_ready, mem_addr, busy); end
    @(negedge clk);
    mem_resp_valid = 0; m0_addr = 32'h300; rst = 1;
    #1;
    checks++; if ({m1_req_ready, m0_req_ready} !== 2'b01) begin failures++; $display("FAIL mid_first_winner got=%b exp=01", {m1_req_ready, m0_req_ready}); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if ({grant_id, mem_req_valid} !== 2'b01 || mem_addr !== 32'h300) begin failures++; $display("FAIL mid_after_grant got=%b addr=%h exp=01 addr=300", {grant_id, mem_req_valid}, mem_addr); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_writeback();
    test_round_robin();
    test_resp_stall();
    test_idle_stray();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
